// File: rtl/seven_segments_to_bcd_capture_if.sv
// Seven-segment snoop bus: scanned display input plus the recovered BCD frame handshake.
interface seven_segments_to_bcd_capture_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    minus;
  logic                    err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output seg, digit_en, out_ready,
    input  bcd_out, minus, err, out_valid
  );

  modport slave (
    input  seg, digit_en, out_ready,
    output bcd_out, minus, err, out_valid
  );
endinterface

// File: rtl/seven_segments_to_bcd_capture.sv
// Recovers packed BCD digits from a digit-scanned seven-segment bus, debouncing each digit
// and handing complete frames downstream on a valid/ready handshake.
module seven_segments_to_bcd_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input logic                          clock,
  input logic                          reset_n,
  seven_segments_to_bcd_capture_if.slave bus
);

  localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
  localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  minus_q, minus_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;

  logic [6:0]            last_q      [NUM_DIGITS];
  logic [3:0]            cnt_q       [NUM_DIGITS];
  logic [3:0]            stg_nib_q   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] stg_minus_q;
  logic [NUM_DIGITS-1:0] stg_err_q;

  logic                  one_hot_c;
  logic [3:0]            cnt_upd_c   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] capture_c;
  logic [3:0]            dec_nib_c;
  logic                  dec_minus_c;
  logic                  dec_err_c;

  // Segment pattern decode (bit0=a .. bit6=g)
  always_comb begin
    dec_nib_c   = 4'hF;
    dec_minus_c = 1'b0;
    dec_err_c   = 1'b0;
    case (bus.seg)
      7'b0111111: dec_nib_c = 4'd0;
      7'b0000110: dec_nib_c = 4'd1;
      7'b1011011: dec_nib_c = 4'd2;
      7'b1001111: dec_nib_c = 4'd3;
      7'b1100110: dec_nib_c = 4'd4;
      7'b1101101: dec_nib_c = 4'd5;
      7'b1111101: dec_nib_c = 4'd6;
      7'b0000111: dec_nib_c = 4'd7;
      7'b1111111: dec_nib_c = 4'd8;
      7'b1100111: dec_nib_c = 4'd9;
      7'b1000000: begin
        dec_nib_c   = 4'd0;
        dec_minus_c = 1'b1;
      end
      default: begin
        dec_nib_c = 4'hF;
        dec_err_c = 1'b1;
      end
    endcase
  end

  // Stabiliser count after this strobe, and which digit (if any) is captured
  always_comb begin
    one_hot_c = $onehot(bus.digit_en);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.seg == last_q[i]) begin
        cnt_upd_c[i] = (cnt_q[i] >= STABLE) ? STABLE : cnt_q[i] + 4'd1;
      end else begin
        cnt_upd_c[i] = 4'd1;
      end
      capture_c[i] = one_hot_c && bus.digit_en[i] && (state_q == COLLECT) &&
                     (cnt_upd_c[i] >= STABLE);
    end
  end

  // Frame FSM next-state and registered-output next values
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    minus_d = minus_q;
    err_d   = err_q;
    valid_d = valid_q;
    mask_d  = mask_q;
    case (state_q)
      COLLECT: begin
        if (mask_q == '1) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_d[4*i +: 4] = stg_nib_q[i];
          end
          minus_d = |stg_minus_q;
          err_d   = |stg_err_q;
          valid_d = 1'b1;
          mask_d  = '0;
          state_d = HOLD;
        end else begin
          mask_d = mask_q | capture_c;
        end
      end
      HOLD: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          mask_d  = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      bcd_q   <= '0;
      minus_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      minus_q <= minus_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
    end
  end

  // Per-digit stabilisers run in every state; staging only fills while collecting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        last_q[i]    <= '0;
        cnt_q[i]     <= '0;
        stg_nib_q[i] <= '0;
      end
      stg_minus_q <= '0;
      stg_err_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (one_hot_c && bus.digit_en[i]) begin
          last_q[i] <= bus.seg;
          cnt_q[i]  <= cnt_upd_c[i];
        end
        if (capture_c[i]) begin
          stg_nib_q[i]   <= dec_nib_c;
          stg_minus_q[i] <= dec_minus_c;
          stg_err_q[i]   <= dec_err_c;
        end
      end
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.minus     = minus_q;
  assign bus.err       = err_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_seven_segments_to_bcd_capture.sv
// Directed and randomized checks of the seven-segment capture block against a
// behavioural frame model kept in the bench.
module tb_seven_segments_to_bcd_capture;

  localparam int unsigned ND = 4;
  localparam int          SC = 3;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  seven_segments_to_bcd_capture_if #(.NUM_DIGITS(ND)) sbus ();

  seven_segments_to_bcd_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sbus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] pat [11];
  localparam logic [6:0] MINUS_PAT = 7'b1000000;

  // Behavioural model state
  logic [6:0]   m_last  [ND];
  int           m_cnt   [ND];
  int           m_sv    [ND];
  bit           m_sm    [ND];
  bit           m_se    [ND];
  bit [ND-1:0]  m_mask;
  bit           m_hold;
  logic         m_valid, m_minus, m_err;
  logic [15:0]  m_bcd;

  function automatic void decode(input logic [6:0] s, output int v, output bit mn, output bit er);
    v = 15; mn = 1'b0; er = 1'b1;
    for (int k = 0; k < 10; k++) if (s == pat[k]) begin v = k; er = 1'b0; end
    if (s == MINUS_PAT) begin v = 0; mn = 1'b1; er = 1'b0; end
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ND; i++) begin
      m_last[i] = '0; m_cnt[i] = 0; m_sv[i] = 0; m_sm[i] = 1'b0; m_se[i] = 1'b0;
    end
    m_mask = '0; m_hold = 1'b0;
    m_valid = 1'b0; m_minus = 1'b0; m_err = 1'b0; m_bcd = '0;
  endtask

  // One clock edge of the frame rules applied to the inputs present at that edge
  task automatic model_edge(input logic [6:0] s, input logic [ND-1:0] en, input logic rdy);
    bit was_collect;
    bit clear;
    bit [ND-1:0] cap;
    was_collect = !m_hold;
    clear = 1'b0;
    cap = '0;
    if (was_collect && m_mask == '1) begin
      m_bcd = '0; m_minus = 1'b0; m_err = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_bcd   = m_bcd + (16'(m_sv[i]) << (4 * i));
        m_minus = m_minus | m_sm[i];
        m_err   = m_err | m_se[i];
      end
      m_valid = 1'b1; m_hold = 1'b1; clear = 1'b1;
    end else if (!was_collect && m_valid && rdy) begin
      m_valid = 1'b0; m_hold = 1'b0; clear = 1'b1;
    end
    if ($countones(en) == 1) begin
      for (int i = 0; i < ND; i++) begin
        if (en[i]) begin
          if (s == m_last[i]) m_cnt[i] = (m_cnt[i] + 1 > SC) ? SC : m_cnt[i] + 1;
          else begin m_last[i] = s; m_cnt[i] = 1; end
          if (was_collect && m_cnt[i] >= SC) begin
            decode(s, m_sv[i], m_sm[i], m_se[i]);
            cap[i] = 1'b1;
          end
        end
      end
    end
    if (clear) m_mask = '0;
    else if (was_collect) m_mask = m_mask | cap;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    expect_val("out_valid", 32'(sbus.out_valid), 32'(m_valid));
    expect_val("bcd_out",   32'(sbus.bcd_out),   32'(m_bcd));
    expect_val("minus",     32'(sbus.minus),     32'(m_minus));
    expect_val("err",       32'(sbus.err),       32'(m_err));
  endtask

  // Drive at negedge, advance one posedge, compare at the following negedge
  task automatic step(input logic [6:0] s, input logic [ND-1:0] en, input logic rdy);
    sbus.seg = s; sbus.digit_en = en; sbus.out_ready = rdy;
    @(posedge clock);
    model_edge(s, en, rdy);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n, input logic rdy);
    logic [ND-1:0] en;
    en = '0;
    en[d] = 1'b1;
    for (int k = 0; k < n; k++) step(s, en, rdy);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3);
    show(0, s0, 3, 1'b0);
    show(1, s1, 3, 1'b0);
    show(2, s2, 3, 1'b0);
    show(3, s3, 3, 1'b0);
  endtask

  task automatic accept_frame(input string tag, input logic [15:0] bcd, input logic mn,
                              input logic er);
    step(7'd0, '0, 1'b0);
    expect_val({tag, "_valid"}, 32'(sbus.out_valid), 32'd1);
    expect_val({tag, "_bcd"},   32'(sbus.bcd_out),   32'(bcd));
    expect_val({tag, "_minus"}, 32'(sbus.minus),     32'(mn));
    expect_val({tag, "_err"},   32'(sbus.err),       32'(er));
    step(7'd0, '0, 1'b1);
    expect_val({tag, "_drop"},  32'(sbus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0]   held;
    logic [ND-1:0] en;
    logic [6:0]    s;
    int            d, n, kind;

    pat[0] = 7'b0111111; pat[1] = 7'b0000110; pat[2] = 7'b1011011; pat[3] = 7'b1001111;
    pat[4] = 7'b1100110; pat[5] = 7'b1101101; pat[6] = 7'b1111101; pat[7] = 7'b0000111;
    pat[8] = 7'b1111111; pat[9] = 7'b1100111; pat[10] = MINUS_PAT;

    reset_n = 1'b0;
    sbus.seg = '0; sbus.digit_en = '0; sbus.out_ready = 1'b0;
    m_reset();
    #12;
    expect_val("rst_valid", 32'(sbus.out_valid), 32'd0);
    expect_val("rst_bcd",   32'(sbus.bcd_out),   32'd0);
    expect_val("rst_minus", 32'(sbus.minus),     32'd0);
    expect_val("rst_err",   32'(sbus.err),       32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic frame: valid rises one cycle after the last digit's third sample
    scan(pat[4], pat[3], pat[2], pat[1]);
    expect_val("lat_early", 32'(sbus.out_valid), 32'd0);
    step(7'd0, '0, 1'b0);
    expect_val("lat_valid", 32'(sbus.out_valid), 32'd1);
    expect_val("t1_bcd",    32'(sbus.bcd_out),   32'h1234);
    expect_val("t1_flags",  {30'd0, sbus.minus, sbus.err}, 32'd0);

    // Frame held while the display keeps changing
    held = sbus.bcd_out;
    for (int k = 0; k < 20; k++) begin
      en = '0;
      en[$urandom_range(ND - 1)] = 1'b1;
      step(pat[$urandom_range(9)], en, 1'b0);
      expect_val("hold_bcd",   32'(sbus.bcd_out),   32'(held));
      expect_val("hold_valid", 32'(sbus.out_valid), 32'd1);
    end
    step(7'd0, '0, 1'b1);
    expect_val("accept_drop", 32'(sbus.out_valid), 32'd0);
    scan(pat[5], pat[6], pat[7], pat[8]);
    accept_frame("new_frame", 16'h8765, 1'b0, 1'b0);

    // Early '1' on digit1 is never accepted
    show(0, pat[4], 3, 1'b0);
    show(1, pat[1], 2, 1'b0);
    show(1, pat[2], 3, 1'b0);
    show(2, pat[2], 3, 1'b0);
    show(3, pat[1], 3, 1'b0);
    accept_frame("debounce", 16'h1224, 1'b0, 1'b0);

    scan(pat[7], pat[6], pat[5], MINUS_PAT);
    accept_frame("minus", 16'h0567, 1'b1, 1'b0);

    scan(pat[9], pat[8], 7'b0000001, pat[3]);
    accept_frame("err", 16'h3F89, 1'b0, 1'b1);

    // Zero / multi-hot strobes leave the stabilisers alone
    show(0, pat[1], 3, 1'b0);
    show(1, pat[2], 2, 1'b0);
    for (int k = 0; k < 5; k++) step(pat[8], (k % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
    show(1, pat[2], 1, 1'b0);
    show(2, pat[3], 3, 1'b0);

    // Asynchronous reset mid-frame
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    expect_val("amid_bcd",   32'(sbus.bcd_out),   32'd0);
    expect_val("amid_valid", 32'(sbus.out_valid), 32'd0);
    expect_val("amid_err",   32'(sbus.err),       32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    show(3, pat[4], 3, 1'b0);
    step(7'd0, '0, 1'b0);
    step(7'd0, '0, 1'b0);
    expect_val("post_rst_novalid", 32'(sbus.out_valid), 32'd0);
    scan(pat[1], pat[2], pat[3], pat[4]);
    accept_frame("post_rst", 16'h4321, 1'b0, 1'b0);

    // Randomized bursts with glitches and random backpressure
    for (int b = 0; b < 150; b++) begin
      d = $urandom_range(ND - 1);
      kind = $urandom_range(9);
      if (kind < 8) s = pat[$urandom_range(9)];
      else if (kind == 8) s = MINUS_PAT;
      else s = 7'($urandom);
      n = $urandom_range(5, 1);
      for (int k = 0; k < n; k++) begin
        en = '0;
        en[d] = 1'b1;
        case ($urandom_range(9))
          0: en = '0;
          1: en = en | ND'(1 << $urandom_range(ND - 1)) | ND'(1 << $urandom_range(ND - 1));
          default: ;
        endcase
        step(s, en, ($urandom_range(3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
